// File: rtl/a2d_arb_pkg.sv
// Shared types and default timing constants for the A2D arbiter.
package a2d_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef logic        owner_t;
   typedef logic [2:0]  chnl_t;
   typedef logic [11:0] res_t;

   localparam int DEF_TIMEOUT_CYC = 4096;
   localparam int DEF_GAP_CYC     = 2;

endpackage

// File: rtl/a2d_arb.sv
// Round-robin arbiter sharing one SPI A2D converter between two clients,
// with an inter-conversion gap and a watchdog against a hung converter.
//
// state | meaning
// IDLE  | waiting for req0/req1, arbitrates and launches strt_cnv
// BUSY  | conversion in flight for owner; watchdog running
// GAP   | mandatory idle clocks after a conversion ends; requests ignored
module a2d_arb
   import a2d_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [2:0]  chnnl0,
   input  logic        req1,
   input  logic [2:0]  chnnl1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [11:0] res0,
   output logic [11:0] res1,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res
);

   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W = 4;

   state_t            state;
   owner_t            owner;
   owner_t            last_owner;
   owner_t            win;
   logic [WD_W-1:0]   wd_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   // Winner for the current request pattern; a tie goes to whoever did not go last.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) begin
         win = ~last_owner;
      end else if (req1) begin
         win = 1'b1;
      end
   end

   // Sequencer: grant, watch the conversion, return result or abort, then hold off.
   // The watchdog is a down-counter loaded at launch; reaching zero while still
   // busy means TIMEOUT_CYC clocks have elapsed since strt_cnv.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         res0       <= '0;
         res1       <= '0;
         strt_cnv   <= 1'b0;
         chnnl      <= '0;
         wd_cnt     <= '0;
         gap_cnt    <= '0;
      end else begin
         strt_cnv <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner    <= win;
                  gnt0     <= ~win;
                  gnt1     <= win;
                  chnnl    <= win ? chnnl1 : chnnl0;
                  strt_cnv <= 1'b1;
                  wd_cnt   <= WD_W'(TIMEOUT_CYC - 1);
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (cnv_cmplt) begin
                  if (owner) begin
                     res1  <= res;
                     done1 <= 1'b1;
                  end else begin
                     res0  <= res;
                     done0 <= 1'b1;
                  end
                  gnt0       <= 1'b0;
                  gnt1       <= 1'b0;
                  last_owner <= owner;
                  gap_cnt    <= GAP_W'(GAP_CYC - 1);
                  state      <= GAP;
               end else if (wd_cnt == '0) begin
                  if (owner) begin
                     err1 <= 1'b1;
                  end else begin
                     err0 <= 1'b1;
                  end
                  gnt0       <= 1'b0;
                  gnt1       <= 1'b0;
                  last_owner <= owner;
                  gap_cnt    <= GAP_W'(GAP_CYC - 1);
                  state      <= GAP;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_a2d_arb.sv
// Self-checking bench for a2d_arb: table vectors, hand sequences for the
// timeout/reset corners, and randomized traffic against a round-robin model.
module tb_a2d_arb;

   localparam int TIMEOUT_CYC = 4096;
   localparam int GAP_CYC     = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [2:0]  chnnl0, chnnl1;
   logic        gnt0, gnt1, done0, done1, err0, err1;
   logic [11:0] res0, res1;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cyc = -1;

   // reference model state: last result per client and who went last
   logic [11:0] m_res0 = '0;
   logic [11:0] m_res1 = '0;
   bit          m_last = 1'b1;

   typedef struct {
      logic        r0;
      logic        r1;
      logic [2:0]  c0;
      logic [2:0]  c1;
      logic [11:0] rv;
      int          lat;
      int          own;
      logic [2:0]  ch;
   } vec_t;

   vec_t vt[7];

   a2d_arb #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .chnnl0(chnnl0), .req1(req1), .chnnl1(chnnl1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .res0(res0), .res1(res1),
      .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL sim_timeout: got no end of test, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_strt(output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < 64) begin
         tick();
         n++;
         if (strt_cnv) begin
            ok = 1'b1;
            break;
         end
      end
      chk("strt_seen", 32'(ok), 32'(1));
   endtask

   // One full conversion: expects owner own on channel exp_ch, A2D answers rv after lat clks.
   task automatic run_conv(input int own, input logic [2:0] exp_ch, input logic [11:0] rv,
                           input int lat, input bit drop_mid, input bit drop_after,
                           input string tag);
      bit ok;
      bit bad;
      int gap;
      wait_strt(ok);
      if (!ok) return;
      if (done_cyc >= 0) begin
         gap = cyc - done_cyc - 1;
         chk({tag, " gap"}, 32'((gap >= GAP_CYC) && (gap <= GAP_CYC + 1)), 32'(1));
      end
      chk({tag, " gnt"}, 32'({gnt1, gnt0}), (own != 0) ? 32'(2) : 32'(1));
      chk({tag, " chnnl"}, 32'(chnnl), 32'(exp_ch));
      bad = 1'b0;
      for (int i = 0; i < lat; i++) begin
         if (drop_mid && i == lat / 2) begin
            if (own != 0) req1 = 1'b0;
            else req0 = 1'b0;
         end
         tick();
         if (chnnl !== exp_ch || strt_cnv || done0 || done1 || err0 || err1 ||
             {gnt1, gnt0} !== ((own != 0) ? 2'b10 : 2'b01)) bad = 1'b1;
      end
      chk({tag, " busy_stable"}, 32'(bad), 32'(0));
      cnv_cmplt = 1'b1;
      res       = rv;
      tick();
      cnv_cmplt = 1'b0;
      res       = 12'($urandom);
      if (own != 0) m_res1 = rv;
      else m_res0 = rv;
      m_last = (own != 0);
      chk({tag, " done"}, 32'({done1, done0}), (own != 0) ? 32'(2) : 32'(1));
      chk({tag, " no_err"}, 32'({err1, err0}), 32'(0));
      chk({tag, " gnt_off"}, 32'({gnt1, gnt0}), 32'(0));
      chk({tag, " res0"}, 32'(res0), 32'(m_res0));
      chk({tag, " res1"}, 32'(res1), 32'(m_res1));
      done_cyc = cyc;
      if (drop_after) begin
         if (own != 0) req1 = 1'b0;
         else req0 = 1'b0;
      end
      tick();
      chk({tag, " done_pulse"}, 32'({done1, done0}), 32'(0));
   endtask

   initial begin
      bit          ok;
      bit          bad;
      int          n;
      int          own;
      logic        p0, p1;
      logic [2:0]  rc0, rc1;

      vt[0] = '{r0:1'b1, r1:1'b1, c0:3'd1, c1:3'd5, rv:12'h123, lat:3, own:1, ch:3'd5};
      vt[1] = '{r0:1'b1, r1:1'b1, c0:3'd4, c1:3'd6, rv:12'h456, lat:1, own:0, ch:3'd4};
      vt[2] = '{r0:1'b0, r1:1'b1, c0:3'd0, c1:3'd3, rv:12'h789, lat:5, own:1, ch:3'd3};
      vt[3] = '{r0:1'b0, r1:1'b1, c0:3'd2, c1:3'd0, rv:12'hFFF, lat:2, own:1, ch:3'd0};
      vt[4] = '{r0:1'b1, r1:1'b1, c0:3'd7, c1:3'd2, rv:12'h000, lat:4, own:0, ch:3'd7};
      vt[5] = '{r0:1'b1, r1:1'b0, c0:3'd6, c1:3'd1, rv:12'hABC, lat:7, own:0, ch:3'd6};
      vt[6] = '{r0:1'b1, r1:1'b1, c0:3'd3, c1:3'd4, rv:12'h5A5, lat:2, own:1, ch:3'd4};

      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; chnnl0 = '0; chnnl1 = '0;
      cnv_cmplt = 1'b0; res = '0;
      tick(); tick();
      chk("rst_ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, strt_cnv, chnnl}), 32'(0));
      chk("rst_res", 32'({res0, res1}), 32'(0));
      rst_n = 1'b1;
      tick();
      chk("idle_ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, strt_cnv, chnnl}), 32'(0));

      // basic client 0 conversion with exact latencies
      req0 = 1'b1; chnnl0 = 3'd2;
      tick();
      chk("basic gnt0", 32'(gnt0), 32'(1));
      chk("basic strt", 32'(strt_cnv), 32'(1));
      chk("basic chnnl", 32'(chnnl), 32'(2));
      tick();
      chk("basic strt_pulse", 32'(strt_cnv), 32'(0));
      tick(); tick();
      cnv_cmplt = 1'b1; res = 12'hA5C;
      tick();
      cnv_cmplt = 1'b0;
      m_res0 = 12'hA5C; m_last = 1'b0;
      chk("basic done0", 32'(done0), 32'(1));
      chk("basic res0", 32'(res0), 32'(m_res0));
      chk("basic gnt0_off", 32'(gnt0), 32'(0));
      req0 = 1'b0;
      done_cyc = cyc;
      tick();
      chk("basic done_pulse", 32'(done0), 32'(0));

      // table vectors
      for (int i = 0; i < 7; i++) begin
         req0 = vt[i].r0; req1 = vt[i].r1; chnnl0 = vt[i].c0; chnnl1 = vt[i].c1;
         run_conv(vt[i].own, vt[i].ch, vt[i].rv, vt[i].lat, 1'b0, 1'b1, $sformatf("vec%0d", i));
         req0 = 1'b0; req1 = 1'b0;
      end

      // fairness with both requests held
      req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'd3; chnnl1 = 3'd4;
      for (int i = 0; i < 6; i++) begin
         run_conv(i % 2, (i % 2 != 0) ? 3'd4 : 3'd3, 12'($urandom), $urandom_range(1, 6),
                  1'b0, 1'b0, $sformatf("fair%0d", i));
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) tick();

      // client 1 conversion that never completes
      req1 = 1'b1; chnnl1 = 3'd7;
      wait_strt(ok);
      chk("to gnt1", 32'(gnt1), 32'(1));
      chk("to chnnl", 32'(chnnl), 32'(7));
      n = 0;
      while (n < TIMEOUT_CYC + 16 && !(err0 || err1 || done0 || done1)) begin
         tick();
         n++;
      end
      chk("to cycles", 32'(n), 32'(TIMEOUT_CYC));
      chk("to err", 32'({err1, err0}), 32'(2));
      chk("to no_done", 32'({done1, done0}), 32'(0));
      chk("to gnt_off", 32'({gnt1, gnt0}), 32'(0));
      chk("to res1_held", 32'(res1), 32'(m_res1));
      req1 = 1'b0; m_last = 1'b1; done_cyc = cyc;
      tick();
      chk("to err_pulse", 32'({err1, err0}), 32'(0));
      req0 = 1'b1; chnnl0 = 3'd4;
      run_conv(0, 3'd4, 12'h321, 3, 1'b0, 1'b1, "after_to");

      // stray completion while idle
      repeat (4) tick();
      cnv_cmplt = 1'b1; res = 12'hFFF;
      tick();
      cnv_cmplt = 1'b0;
      chk("stray ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, strt_cnv}), 32'(0));
      chk("stray res", 32'({res0, res1}), 32'({m_res0, m_res1}));
      done_cyc = -1;

      // completion on the watchdog terminal clock
      req0 = 1'b1; chnnl0 = 3'd3;
      wait_strt(ok);
      bad = 1'b0;
      for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
         tick();
         if (done0 || done1 || err0 || err1 || !gnt0) bad = 1'b1;
      end
      chk("tc busy", 32'(bad), 32'(0));
      cnv_cmplt = 1'b1; res = 12'h3C3;
      tick();
      cnv_cmplt = 1'b0;
      m_res0 = 12'h3C3; m_last = 1'b0;
      chk("tc done_no_err", 32'({done1, done0, err1, err0}), 32'(4'b0100));
      chk("tc res0", 32'(res0), 32'(m_res0));
      req0 = 1'b0;
      tick();
      chk("tc after", 32'({done1, done0, err1, err0}), 32'(0));

      // reset in the middle of a client 0 conversion
      repeat (3) tick();
      req0 = 1'b1; chnnl0 = 3'd1;
      wait_strt(ok);
      repeat (100) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, strt_cnv, chnnl}), 32'(0));
      chk("mid_rst res", 32'({res0, res1}), 32'(0));
      m_res0 = '0; m_res1 = '0; m_last = 1'b1; done_cyc = -1;
      req0 = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      cnv_cmplt = 1'b1; res = 12'hABC;
      tick();
      cnv_cmplt = 1'b0;
      chk("late_cmplt ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1}), 32'(0));
      chk("late_cmplt res", 32'({res0, res1}), 32'(0));
      req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'd2; chnnl1 = 3'd6;
      run_conv(0, 3'd2, 12'h777, 2, 1'b0, 1'b1, "post_rst_tie");
      req0 = 1'b0; req1 = 1'b0;

      // req0 dropped mid-conversion
      req0 = 1'b1; chnnl0 = 3'd5;
      run_conv(0, 3'd5, 12'h9E1, 8, 1'b1, 1'b1, "drop_mid");

      // randomized traffic against the round-robin model
      p0 = 1'b0; p1 = 1'b0; rc0 = '0; rc1 = '0;
      for (int t = 0; t < 30; t++) begin
         if (!p0 && $urandom_range(0, 1) == 1) begin
            p0 = 1'b1; rc0 = 3'($urandom_range(0, 7));
         end
         if (!p1 && $urandom_range(0, 1) == 1) begin
            p1 = 1'b1; rc1 = 3'($urandom_range(0, 7));
         end
         if (!p0 && !p1) begin
            p0 = 1'b1; rc0 = 3'($urandom_range(0, 7));
         end
         req0 = p0; req1 = p1; chnnl0 = rc0; chnnl1 = rc1;
         if (p0 && p1) own = m_last ? 0 : 1;
         else own = p1 ? 1 : 0;
         run_conv(own, (own != 0) ? rc1 : rc0, 12'($urandom), $urandom_range(1, 12),
                  $urandom_range(0, 3) == 0, 1'b1, $sformatf("rnd%0d", t));
         if (own != 0) p1 = 1'b0;
         else p0 = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
